// File: rtl/ntt_bank_agu_pkg.sv
// ---------------------------------------------------------------------------
// ntt_bank_agu_pkg
// Shared parameter defaults, the sequencer state encoding and a width helper
// for the NTT/INTT butterfly address generator and its bank map.
//   P_DEF    : butterflies per cycle (2*P lanes, 2*P a power of two)
//   MAP_DEF  : log2(2*P), bank-index width
//   LOGN_DEF : log2 of the polynomial length
//   BA_W_DEF : bank-address width (LOGN - MAP)
// ---------------------------------------------------------------------------
package ntt_bank_agu_pkg;

    localparam int P_DEF    = 4;
    localparam int MAP_DEF  = 3;
    localparam int LOGN_DEF = 8;
    localparam int BA_W_DEF = LOGN_DEF - MAP_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } agu_state_t;

    // Width of the stage number; kept at least one bit wide.
    function automatic int stage_width(input int logn);
        return (logn <= 2) ? 1 : $clog2(logn);
    endfunction

endpackage

// File: rtl/ntt_bank_agu_if.sv
// ---------------------------------------------------------------------------
// ntt_bank_agu_if
// Command and beat-stream bundle of the butterfly address generator.
//   start, mode, out_ready : driven by the controller / downstream side
//   busy, out_valid, BI_bus, BA_bus, stage_o, last_o, done : driven by the AGU
// modport master : controller / consumer side
// modport slave  : the address generator itself
// ---------------------------------------------------------------------------
interface ntt_bank_agu_if
    import ntt_bank_agu_pkg::*;
#(
    parameter int P    = P_DEF,
    parameter int MAP  = MAP_DEF,
    parameter int LOGN = LOGN_DEF,
    parameter int BA_W = LOGN - MAP
) ();

    localparam int BI_PACK = 2 * P * MAP;
    localparam int BA_PACK = 2 * P * BA_W;
    localparam int SW      = stage_width(LOGN);

    logic               start;
    logic               mode;
    logic               out_ready;
    logic               busy;
    logic               out_valid;
    logic [BI_PACK-1:0] BI_bus;
    logic [BA_PACK-1:0] BA_bus;
    logic [SW-1:0]      stage_o;
    logic               last_o;
    logic               done;

    modport master (
        output start, mode, out_ready,
        input  busy, out_valid, BI_bus, BA_bus, stage_o, last_o, done
    );

    modport slave (
        input  start, mode, out_ready,
        output busy, out_valid, BI_bus, BA_bus, stage_o, last_o, done
    );

endinterface

// File: rtl/ntt_bank_map.sv
// ---------------------------------------------------------------------------
// ntt_bank_map
// Combinational map of one coefficient address onto (bank index, bank addr).
//   x  : LOGN-bit coefficient address
//   bi : MAP-bit bank index  = {parity of x[LOGN-1:LOGP], x[LOGP-1:0]}
//   ba : BA_W-bit bank address = x[LOGN-1:LOGP+1]
// The parity bit spreads the two halves of every butterfly over different
// banks, which is what keeps each beat conflict-free.
// ---------------------------------------------------------------------------
module ntt_bank_map #(
    parameter int LOGN = 8,
    parameter int MAP  = 3,
    parameter int BA_W = LOGN - MAP
) (
    input  logic [LOGN-1:0] x,
    output logic [MAP-1:0]  bi,
    output logic [BA_W-1:0] ba
);

    localparam int LOGP = MAP - 1;

    assign bi = {^x[LOGN-1:LOGP], x[LOGP-1:0]};
    assign ba = x[LOGN-1:LOGP+1];

endmodule

// File: rtl/ntt_bank_agu.sv
// ---------------------------------------------------------------------------
// ntt_bank_agu
// Per-cycle butterfly operand address generator for the 2*P-lane NTT/INTT
// datapath, with the bank map applied to every lane.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : ntt_bank_agu_if.slave
//           start/mode   - begin a transform (mode 0 = NTT, 1 = INTT)
//           out_ready    - downstream accepts the current beat
//           busy         - transform in progress
//           out_valid    - BI_bus/BA_bus/stage_o/last_o valid
//           BI_bus       - lane i bank index at [i*MAP +: MAP]
//           BA_bus       - lane i bank address at [i*BA_W +: BA_W]
//           stage_o      - stage of the current beat
//           last_o       - final beat of its stage
//           done         - pulse after the final beat is accepted
// Pipeline: counters -> S1 (addresses) -> bank map -> S2 (outputs).
// ---------------------------------------------------------------------------
module ntt_bank_agu
    import ntt_bank_agu_pkg::*;
#(
    parameter int P    = P_DEF,
    parameter int MAP  = MAP_DEF,
    parameter int LOGN = LOGN_DEF,
    parameter int BA_W = LOGN - MAP
) (
    input  logic          clk,
    input  logic          rst_n,
    ntt_bank_agu_if.slave bus
);

    localparam int LANES   = 2 * P;
    localparam int LOGP    = MAP - 1;
    localparam int CW      = LOGN - MAP;
    localparam int SW      = stage_width(LOGN);
    localparam int AP      = LANES * LOGN;
    localparam int BI_PACK = LANES * MAP;
    localparam int BA_PACK = LANES * BA_W;

    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [SW-1:0] STAGE_MAX = SW'(LOGN - 1);

    agu_state_t         state_reg, state_next;
    logic               done_reg, done_next;
    logic               mode_reg;
    logic [CW-1:0]      cnt_reg;
    logic [SW-1:0]      stage_reg;

    logic               en;
    logic               beat_last;
    logic               final_issue;
    logic               final_accept;

    logic [SW-1:0]      half_log;
    logic [LOGN-1:0]    h_one;
    logic [LOGN-1:0]    h_mask;
    logic [AP-1:0]      gen_addr;

    logic               s1_valid_reg;
    logic               s1_last_reg;
    logic [SW-1:0]      s1_stage_reg;
    logic [AP-1:0]      s1_addr_reg;

    logic [BI_PACK-1:0] map_bi;
    logic [BA_PACK-1:0] map_ba;

    logic               out_valid_reg;
    logic               last_reg;
    logic [SW-1:0]      stage_o_reg;
    logic [BI_PACK-1:0] bi_reg;
    logic [BA_PACK-1:0] ba_reg;

    // Whole pipeline, counters included, moves only when the output slot
    // is free or being taken.
    assign en           = bus.out_ready | ~out_valid_reg;
    assign beat_last    = (cnt_reg == CNT_MAX);
    assign final_issue  = (state_reg == ST_RUN) && en && beat_last &&
                          (stage_reg == STAGE_MAX);
    assign final_accept = out_valid_reg && bus.out_ready && last_reg &&
                          (stage_o_reg == STAGE_MAX);

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (final_issue) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (final_accept) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- stage / beat counters ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg  <= 1'b0;
            cnt_reg   <= '0;
            stage_reg <= '0;
        end else if (state_reg == ST_IDLE) begin
            if (bus.start) begin
                mode_reg  <= bus.mode;
                cnt_reg   <= '0;
                stage_reg <= '0;
            end
        end else if (state_reg == ST_RUN && en) begin
            cnt_reg <= cnt_reg + CW'(1);
            if (beat_last && stage_reg != STAGE_MAX)
                stage_reg <= stage_reg + SW'(1);
        end
    end

    // ---------------- address generation ----------------
    // log2 of the half-distance: NTT starts at N/2 and halves, INTT starts
    // at 1 and doubles.
    assign half_log = mode_reg ? stage_reg : (STAGE_MAX - stage_reg);
    assign h_one    = LOGN'(1) << half_log;
    assign h_mask   = h_one - LOGN'(1);

    // k = cnt*P + p. Inserting a zero at bit position log2(h) turns k into
    // a = (k/h)*2h + k%h; setting that bit gives b = a + h.
    for (genvar gi = 0; gi < P; gi++) begin : g_bfly
        logic [LOGN-1:0] k;
        logic [LOGN-1:0] a;
        assign k = {1'b0, cnt_reg, LOGP'(gi)};
        assign a = ((k & ~h_mask) << 1) | (k & h_mask);
        assign gen_addr[(2*gi)*LOGN   +: LOGN] = a;
        assign gen_addr[(2*gi+1)*LOGN +: LOGN] = a | h_one;
    end

    // ---------------- S1: raw addresses ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_stage_reg <= '0;
            s1_addr_reg  <= '0;
        end else if (en) begin
            s1_valid_reg <= (state_reg == ST_RUN);
            s1_last_reg  <= beat_last;
            s1_stage_reg <= stage_reg;
            s1_addr_reg  <= gen_addr;
        end
    end

    // ---------------- bank map per lane ----------------
    for (genvar gi = 0; gi < LANES; gi++) begin : g_map
        ntt_bank_map #(
            .LOGN (LOGN),
            .MAP  (MAP),
            .BA_W (BA_W)
        ) u_map (
            .x  (s1_addr_reg[gi*LOGN +: LOGN]),
            .bi (map_bi[gi*MAP +: MAP]),
            .ba (map_ba[gi*BA_W +: BA_W])
        );
    end

    // ---------------- S2: output registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            last_reg      <= 1'b0;
            stage_o_reg   <= '0;
            bi_reg        <= '0;
            ba_reg        <= '0;
        end else if (en) begin
            out_valid_reg <= s1_valid_reg;
            last_reg      <= s1_last_reg;
            stage_o_reg   <= s1_stage_reg;
            bi_reg        <= map_bi;
            ba_reg        <= map_ba;
        end
    end

    assign bus.busy      = (state_reg != ST_IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.BI_bus    = bi_reg;
    assign bus.BA_bus    = ba_reg;
    assign bus.stage_o   = stage_o_reg;
    assign bus.last_o    = last_reg;
    assign bus.done      = done_reg;

endmodule

// File: tb/tb_ntt_bank_agu.sv
// ---------------------------------------------------------------------------
// tb_ntt_bank_agu
// Directed bench for ntt_bank_agu at the default parameters (P=4, N=256).
// Each accepted beat is compared against an index-arithmetic reference of
// the butterfly schedule; hand-computed beats, backpressure, start-while-busy
// and mid-run reset are covered by the directed steps.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ntt_bank_agu;

    localparam int P       = 4;
    localparam int MAP     = 3;
    localparam int LOGN    = 8;
    localparam int BA_W    = 5;
    localparam int LANES   = 8;
    localparam int BI_PACK = 24;
    localparam int BA_PACK = 40;
    localparam int BPS     = 32;
    localparam int TOTAL   = 256;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    ntt_bank_agu_if #(.P(P), .MAP(MAP), .LOGN(LOGN), .BA_W(BA_W)) bus ();

    ntt_bank_agu #(.P(P), .MAP(MAP), .LOGN(LOGN), .BA_W(BA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference butterfly schedule using plain division and modulo.
    function automatic int ref_addr(input logic m, input int st, input int cnt, input int lane);
        int h, k, g, o, a;
        h = m ? (1 << st) : (256 >> (st + 1));
        k = cnt * P + lane / 2;
        g = k / h;
        o = k % h;
        a = g * 2 * h + o;
        return (lane % 2 == 1) ? a + h : a;
    endfunction

    function automatic logic [2:0] ref_bi(input int x);
        logic [7:0] v;
        v = 8'(x);
        return {^v[7:2], v[1:0]};
    endfunction

    function automatic logic [4:0] ref_ba(input int x);
        logic [7:0] v;
        v = 8'(x);
        return v[7:3];
    endfunction

    function automatic logic [BI_PACK-1:0] pack_bi(input int v [8]);
        logic [BI_PACK-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) r[i*MAP +: MAP] = 3'(v[i]);
        return r;
    endfunction

    function automatic logic [BA_PACK-1:0] pack_ba(input int v [8]);
        logic [BA_PACK-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) r[i*BA_W +: BA_W] = 5'(v[i]);
        return r;
    endfunction

    // One complete transform with the consumer modelled inline.
    task automatic run_xform(input logic m, input int stall_beat, input bit spam,
                             output logic [BI_PACK-1:0] bi0, output logic [BA_PACK-1:0] ba0,
                             output logic [BI_PACK-1:0] bi31, output logic [BA_PACK-1:0] ba31,
                             output logic last31);
        int cyc, beats, done_cnt, stall_cnt, first_valid, last_acc, seen_cnt, st, cn;
        bit finished, hold_pending;
        bit seen [256];
        logic [BI_PACK-1:0] hbi, ebi;
        logic [BA_PACK-1:0] hba, eba;
        logic [2:0] hstage;
        logic hlast;
        logic [7:0] perm;
        logic [2:0] obi;
        logic [4:0] oba;
        logic [7:0] x;
        int ea;

        beats = 0; done_cnt = 0; stall_cnt = 0; first_valid = -1; last_acc = -100;
        seen_cnt = 0; finished = 0; hold_pending = 0;
        hbi = '0; hba = '0; hstage = '0; hlast = 1'b0;
        bi0 = '0; ba0 = '0; bi31 = '0; ba31 = '0; last31 = 1'b0;
        for (int i = 0; i < 256; i++) seen[i] = 0;

        bus.mode = m;
        bus.start = 1'b1;
        bus.out_ready = 1'b1;
        step();
        cyc = 1;
        bus.start = 1'b0;
        chk("busy_rise", bus.busy, 1);

        while (!finished && cyc < 3000) begin
            if (bus.done) begin
                done_cnt++;
                chk("done_timing", last_acc, cyc - 1);
                chk("busy_fall", bus.busy, 0);
                finished = 1;
            end else begin
                if (hold_pending) begin
                    chk("hold_valid", bus.out_valid, 1);
                    chk("hold_bi", bus.BI_bus, hbi);
                    chk("hold_ba", bus.BA_bus, hba);
                    chk("hold_stage", bus.stage_o, hstage);
                    chk("hold_last", bus.last_o, hlast);
                    hold_pending = 0;
                end
                if (bus.out_valid && first_valid < 0) first_valid = cyc;

                if (beats == stall_beat && stall_cnt < 5) begin
                    bus.out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    bus.out_ready = 1'b1;
                end

                if (spam && cyc == 60) begin
                    bus.start = 1'b1;
                    bus.mode = ~m;
                end else begin
                    bus.start = 1'b0;
                end

                if (bus.out_valid && bus.out_ready) begin
                    st = beats / BPS;
                    cn = beats % BPS;
                    ebi = '0;
                    eba = '0;
                    for (int l = 0; l < LANES; l++) begin
                        ea = ref_addr(m, st, cn, l);
                        ebi[l*MAP +: MAP] = ref_bi(ea);
                        eba[l*BA_W +: BA_W] = ref_ba(ea);
                    end
                    chk("beat_bi", bus.BI_bus, ebi);
                    chk("beat_ba", bus.BA_bus, eba);
                    chk("beat_stage", bus.stage_o, st);
                    chk("beat_last", bus.last_o, (cn == BPS - 1));

                    // Recover each lane's address from what the DUT emitted.
                    if (cn == 0) begin
                        for (int i = 0; i < 256; i++) seen[i] = 0;
                        seen_cnt = 0;
                    end
                    perm = '0;
                    for (int l = 0; l < LANES; l++) begin
                        obi = bus.BI_bus[l*MAP +: MAP];
                        oba = bus.BA_bus[l*BA_W +: BA_W];
                        perm[obi] = 1'b1;
                        x = {oba, obi[2] ^ (^oba), obi[1:0]};
                        if (!seen[x]) seen_cnt++;
                        seen[x] = 1;
                    end
                    chk("beat_perm", perm, 8'hFF);
                    if (cn == BPS - 1) chk("stage_cover", seen_cnt, 256);

                    if (beats == 0) begin bi0 = bus.BI_bus; ba0 = bus.BA_bus; end
                    if (beats == 31) begin bi31 = bus.BI_bus; ba31 = bus.BA_bus; last31 = bus.last_o; end
                    beats++;
                    last_acc = cyc;
                end else if (bus.out_valid) begin
                    hold_pending = 1;
                    hbi = bus.BI_bus;
                    hba = bus.BA_bus;
                    hstage = bus.stage_o;
                    hlast = bus.last_o;
                end
                step();
                cyc++;
            end
        end

        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        chk("done_count", done_cnt, 1);
        chk("total_beats", beats, TOTAL);
        chk("first_valid_lat", first_valid, 3);
        step();
        chk("done_pulse_end", bus.done, 0);
    endtask

    initial begin
        int hb [8];
        int hba_v [8];
        int cnt, guard, dcount;
        logic [BI_PACK-1:0] bi0, bi31;
        logic [BA_PACK-1:0] ba0, ba31;
        logic last31;

        rst_n = 1'b1;
        bus.start = 1'b0;
        bus.mode = 1'b0;
        bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_bi", bus.BI_bus, 0);
        chk("rst_ba", bus.BA_bus, 0);
        chk("rst_done", bus.done, 0);
        rst_n = 1'b1;
        step();

        // NTT full run, hand-checked first beat
        run_xform(1'b0, -1, 1'b0, bi0, ba0, bi31, ba31, last31);
        hb = '{0, 4, 1, 5, 2, 6, 3, 7};
        hba_v = '{0, 16, 0, 16, 0, 16, 0, 16};
        chk("ntt_beat0_bi", bi0, pack_bi(hb));
        chk("ntt_beat0_ba", ba0, pack_ba(hba_v));

        // INTT full run, hand-checked first beat and end of stage 0
        run_xform(1'b1, -1, 1'b0, bi0, ba0, bi31, ba31, last31);
        hb = '{0, 1, 2, 3, 4, 5, 6, 7};
        hba_v = '{0, 0, 0, 0, 0, 0, 0, 0};
        chk("intt_beat0_bi", bi0, pack_bi(hb));
        chk("intt_beat0_ba", ba0, pack_ba(hba_v));
        hb = '{4, 5, 6, 7, 0, 1, 2, 3};
        hba_v = '{31, 31, 31, 31, 31, 31, 31, 31};
        chk("intt_beat31_bi", bi31, pack_bi(hb));
        chk("intt_beat31_ba", ba31, pack_ba(hba_v));
        chk("intt_beat31_last", last31, 1);

        // Backpressure: 5 stalled cycles in the middle of stage 1
        run_xform(1'b0, 40, 1'b0, bi0, ba0, bi31, ba31, last31);

        // start pulsed and mode flipped mid-transform
        run_xform(1'b1, -1, 1'b1, bi0, ba0, bi31, ba31, last31);

        // Reset during beat 100 aborts the transform
        bus.mode = 1'b0;
        bus.start = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.start = 1'b0;
        cnt = 0;
        guard = 0;
        while (cnt < 100 && guard < 500) begin
            if (bus.out_valid) cnt++;
            if (cnt < 100) step();
            guard++;
        end
        chk("abort_reach", cnt, 100);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_bi", bus.BI_bus, 0);
        chk("abort_ba", bus.BA_bus, 0);
        chk("abort_stage", bus.stage_o, 0);
        chk("abort_last", bus.last_o, 0);
        chk("abort_busy", bus.busy, 0);
        step();
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) dcount++;
            step();
        end
        chk("abort_no_done", dcount, 0);
        chk("abort_idle", bus.busy, 0);

        // Fresh start after the abort begins again from stage 0
        run_xform(1'b0, -1, 1'b0, bi0, ba0, bi31, ba31, last31);
        hb = '{0, 4, 1, 5, 2, 6, 3, 7};
        chk("restart_beat0_bi", bi0, pack_bi(hb));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ntt_bank_agu.md
# ntt_bank_agu

- Generates the per-cycle butterfly operand addresses for the multi-lane NTT/INTT datapath and maps them onto the 2·`P` memory banks.
- Sits directly upstream of the bank arbiter:
  - its `BI_bus` output (one `MAP`-bit bank index per lane) feeds the arbiter's inverse-permutation input;
  - `BA_bus` goes to the bank address ports.
- The index map is conflict-free by construction, so every beat's `BI_bus` is a permutation of 0..2P−1.

## Interface
Parameters (all from `parameter.v`):
- `P`, default 4: butterflies per cycle; 2P lanes; 2P must be a power of two.
- `MAP`, default 3: log2(2P), the bank-index width.
- `LOGN`, default 8: log2 of the polynomial length N (default 256).
- `BA_W`, default LOGN−MAP: bank-address width.
- `BI_PACK` = 2P·MAP; `BA_PACK` = 2P·BA_W.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle request to begin a transform; ignored while `busy`.
- `mode` in 1: 0 = NTT (Cooley-Tukey, distance halves); 1 = INTT (Gentleman-Sande, distance doubles). Sampled with `start`.
- `out_ready` in 1: downstream accepts the current beat.
- `busy` out 1: a transform is in progress.
- `out_valid` out 1: `BI_bus`, `BA_bus`, `stage_o` and `last_o` are valid.
- `BI_bus` out BI_PACK: lane i bank index at bits [i·MAP+:MAP].
- `BA_bus` out BA_PACK: lane i bank address at bits [i·BA_W+:BA_W].
- `stage_o` out log2(LOGN): stage number of the current beat.
- `last_o` out 1: final beat of the current stage.
- `done` out 1: one-cycle pulse after the final beat of the final stage is accepted.

## Operation
- **FSM states:** IDLE, RUN, DRAIN.
  - IDLE→RUN on `start`; loads `mode` and clears the counters.
  - RUN→DRAIN after the last beat of stage LOGN−1 is issued into the pipeline.
  - DRAIN→IDLE when that beat is accepted at the output; `done` pulses in that cycle.
- **Counters:** `stage` runs 0..LOGN−1; `cnt` runs 0..N/(2P)−1 within a stage. `cnt` wraps to 0 and `stage` increments when `cnt` = N/(2P)−1 and the pipeline advances.
- **Half-distance per stage:** NTT h = N>>(stage+1); INTT h = 1<<stage.
- **Per butterfly p (0..P−1):**
  - k = cnt·P+p; g = k/h; o = k mod h.
  - a = g·2h+o; b = a+h.
  - Lane 2p carries a; lane 2p+1 carries b.
  - All shifts and masks are exact powers of two; no dividers.
- **Bank map for address x (LOGN bits, LOGP = MAP−1):**
  - BI = {^x[LOGN−1:LOGP], x[LOGP−1:0]}.
  - BA = x[LOGN−1:LOGP+1].
- **Conflict-freedom follows from the construction:**
  - If h ≥ P, the a's are P aligned contiguous addresses and each b differs from its a in one bit ≥ LOGP, which flips the parity bit.
  - If h < P, the beat covers one aligned 2P block.
- **Total beats:** LOGN·N/(2P), i.e. 256 at the defaults.

## Timing
- **Reset:** asynchronous on `rst_n` low. Clears FSM to IDLE, counters, both pipeline valids, and all outputs to 0.
- **Pipeline:**
  - S1 registers the 2P addresses plus stage/last/valid.
  - S2 registers BI/BA plus stage/last/valid (the outputs).
  - `start` high in cycle c gives `busy` high in c+1 and first `out_valid` in c+3 when `out_ready` is held high.
- **Stall:**
  - Enable en = `out_ready` | ~`out_valid`. The counters, S1 and S2 advance only on en.
  - While `out_valid`=1 and `out_ready`=0, all outputs are held stable.
  - Bubbles are squeezed when `out_valid`=0.
- **Throughput:** one beat per cycle under continuous `out_ready`.
- **Completion:** `busy` falls in the same cycle `done` pulses.
- **Boundary cases:**
  - `start` while busy has no effect.
  - `mode` changes mid-transform are ignored.
  - `rst_n` asserted mid-transform aborts with no `done`.

## Structure
- `parameter.v` gains `LOGN`, `N`, `BA_W` and `BA_PACK` alongside the existing `P`, `MAP` and `BI_PACK`.
- Sub-module `ntt_bank_map`: combinational x → {BI, BA}, instantiated 2P times between S1 and S2.
- The FSM, counters and address generation live in the top module.

## Test plan
- **NTT stage 0, cnt 0:** reset, `start` with `mode`=0, ready high.
  - Beat 0: addresses 0,128,1,129,2,130,3,131.
  - BI per lane 0,4,1,5,2,6,3,7.
  - BA 0,16,0,16,0,16,0,16.
  - `stage_o`=0.
- **INTT stage 0, cnt 0:** `mode`=1.
  - Beat 0: addresses 0..7; BI 0..7; BA all 0.
  - Beat 31 has `last_o`=1 and addresses 248..255.
- **Full run:** exactly 256 beats; every beat's BI is a permutation of 0..7; each address appears once per stage; `done` pulses once, one cycle after the last accepted beat.
- **Backpressure:** drop `out_ready` for 5 cycles mid-stage. Outputs are held bit-exact, no beat is lost or duplicated, and the total is still 256.
- **Control:** `start` pulsed while busy is ignored (still exactly 256 beats). `rst_n` low for 1 cycle at beat 100 zeroes all outputs immediately; a new `start` restarts from stage 0.
